// File: rtl/gcd_rr_scheduler_if.sv
// Request/response bus between client blocks and the shared GCD scheduler.
// Operands are packed per requester: client i at [i*WIDTH +: WIDTH].
interface gcd_rr_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_data;
    logic                   rsp_err;
    logic                   rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end sharing one subtraction GCD unit among N_REQ clients.
// Zero operands bypass the unit; a watchdog aborts a hung computation.
module gcd_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    gcd_rr_scheduler_if.slave bus,
    output logic              busy,
    output logic              gcd_start,
    output logic [WIDTH-1:0]  gcd_a,
    output logic [WIDTH-1:0]  gcd_b,
    output logic              gcd_rst,
    input  logic              gcd_done,
    input  logic [WIDTH-1:0]  gcd_result
);
    localparam int IDW = $clog2(N_REQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_ABORT,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic [WDW-1:0]   wd_q, wd_d;

    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   win;
    logic             found;
    logic [N_REQ-1:0] grant;
    logic [WIDTH-1:0] sel_a, sel_b;

    // Scan last+1, last+2, ... with wrap; first valid requester wins.
    always_comb begin
        cand  = last_q;
        win   = last_q;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == IDW'(N_REQ - 1)) ? '0 : cand + IDW'(1);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        grant = '0;
        if (state_q == S_IDLE && found) begin
            grant[win] = 1'b1;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win == IDW'(k)) begin
                sel_a = bus.req_a[k*WIDTH +: WIDTH];
                sel_b = bus.req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        err_d   = err_q;
        wd_d    = wd_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    a_d    = sel_a;
                    b_d    = sel_b;
                    id_d   = win;
                    last_d = win;
                    if (sel_a == '0 || sel_b == '0) begin
                        data_d  = sel_a | sel_b;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done strobe on the limit cycle still counts as success.
                if (gcd_done) begin
                    state_d = S_CAPTURE;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_CAPTURE: begin
                data_d  = gcd_result;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_ABORT: begin
                data_d  = '0;
                err_d   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= IDW'(N_REQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign gcd_start     = (state_q == S_ISSUE);
    assign gcd_rst       = (state_q == S_ABORT);
    assign gcd_a         = a_q;
    assign gcd_b         = b_q;
    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Bench for gcd_rr_scheduler: vector table, directed corner sequences and a
// randomized run scored against a transaction-level round-robin/GCD model.
module tb_gcd_rr_scheduler;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         busy, gcd_start, gcd_rst;
    logic [W-1:0] gcd_a, gcd_b;
    logic         gcd_done;
    logic [W-1:0] gcd_result;

    int n_pass  = 0;
    int n_total = 0;
    int n_start = 0;
    int n_grst  = 0;
    int stub_lat = 1;
    int rem = 0;
    logic [W-1:0] stub_res;

    gcd_rr_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus ();

    gcd_rr_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .gcd_start (gcd_start),
        .gcd_a     (gcd_a),
        .gcd_b     (gcd_b),
        .gcd_rst   (gcd_rst),
        .gcd_done  (gcd_done),
        .gcd_result(gcd_result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        int x, y, t;
        x = int'(a);
        y = int'(b);
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(0, 7) == 0) return '0;
        return W'($urandom_range(1, 255));
    endfunction

    // GCD unit stand-in: done strobe in WAIT cycle stub_lat-1; 0 = never.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem        <= 0;
            gcd_done   <= 1'b0;
            gcd_result <= '0;
            stub_res   <= '0;
        end else if (gcd_rst) begin
            rem      <= 0;
            gcd_done <= 1'b0;
        end else if (gcd_start) begin
            rem      <= stub_lat;
            gcd_done <= (stub_lat == 1);
            stub_res <= gcd_ref(gcd_a, gcd_b);
        end else if (gcd_done) begin
            gcd_done   <= 1'b0;
            gcd_result <= stub_res;
            rem        <= 0;
        end else if (rem > 1) begin
            rem      <= rem - 1;
            gcd_done <= (rem == 2);
        end
    end

    always @(negedge clk) begin
        if (gcd_start) n_start++;
        if (gcd_rst) n_grst++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_valid[id]      = 1'b1;
        bus.req_a[id*W +: W]   = a;
        bus.req_b[id*W +: W]   = b;
    endtask

    task automatic wait_any_ready();
        int n = 0;
        while (bus.req_ready == '0 && n < 200) begin
            tick();
            #1;
            n++;
        end
    endtask

    task automatic wait_rsp(input string nm);
        int n = 0;
        while (!bus.rsp_valid && n < 200) begin
            tick();
            #1;
            n++;
        end
        chk(nm, bus.rsp_valid, 1);
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        logic [W-1:0] ed;
        logic         ee;
        int           es;
    } vec_t;

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] d;
        logic         e;
    } exp_t;

    vec_t         tbl[8];
    vec_t         v;
    exp_t         e;
    exp_t         q[$];
    logic [W-1:0] pa[N];
    logic [W-1:0] pb[N];
    logic [N-1:0] pend;
    int           ptr, ew, win, lat, s0, r0, n;
    logic         gen, seen, bypass;

    initial begin
        tbl[0] = '{0, 8'd12,  8'd18, 5,  8'd6,  1'b0, 1};
        tbl[1] = '{2, 8'd0,   8'd35, 1,  8'd35, 1'b0, 0};
        tbl[2] = '{2, 8'd0,   8'd0,  1,  8'd0,  1'b0, 0};
        tbl[3] = '{1, 8'd255, 8'd1,  3,  8'd1,  1'b0, 1};
        tbl[4] = '{3, 8'd48,  8'd0,  1,  8'd48, 1'b0, 0};
        tbl[5] = '{1, 8'd100, 8'd75, 16, 8'd25, 1'b0, 1};
        tbl[6] = '{0, 8'd9,   8'd6,  17, 8'd0,  1'b1, 1};
        tbl[7] = '{3, 8'd13,  8'd13, 1,  8'd13, 1'b0, 1};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        pend          = '0;
        ptr           = N - 1;

        #3;
        chk("reset_outputs",
            {busy, gcd_start, gcd_rst, gcd_a, gcd_b, bus.rsp_valid,
             bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req_ready}, 0);
        tick();
        tick();
        rst = 1'b0;

        foreach (tbl[i]) begin
            v = tbl[i];
            bus.rsp_ready = 1'b1;
            stub_lat = v.lat;
            put(v.id, v.a, v.b);
            #1;
            wait_any_ready();
            chk($sformatf("v%0d_ready", i), bus.req_ready, 64'(1) << v.id);
            s0 = n_start;
            r0 = n_grst;
            tick();
            bus.req_valid = '0;
            #1;
            if (v.es == 0) chk($sformatf("v%0d_bypass_lat", i), bus.rsp_valid, 1);
            wait_rsp($sformatf("v%0d_rsp_seen", i));
            chk($sformatf("v%0d_id", i), bus.rsp_id, v.id);
            chk($sformatf("v%0d_data", i), bus.rsp_data, v.ed);
            chk($sformatf("v%0d_err", i), bus.rsp_err, v.ee);
            tick();
            #1;
            chk($sformatf("v%0d_busy_after", i), busy, 0);
            chk($sformatf("v%0d_starts", i), n_start - s0, v.es);
            chk($sformatf("v%0d_aborts", i), n_grst - r0, v.ee);
            ptr = v.id;
        end

        // Every requester valid all the time: strict rotation.
        stub_lat = 2;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) put(i, 8'd7, 8'd7);
        #1;
        for (int k = 0; k < 5; k++) begin
            ew = (ptr + 1) % N;
            wait_any_ready();
            chk($sformatf("rr%0d_grant", k), bus.req_ready, 64'(1) << ew);
            ptr = ew;
            tick();
            #1;
            wait_rsp($sformatf("rr%0d_rsp_seen", k));
            chk($sformatf("rr%0d_id", k), bus.rsp_id, ew);
            chk($sformatf("rr%0d_data", k), bus.rsp_data, 7);
            tick();
            if (k == 4) bus.req_valid = '0;
            #1;
        end

        // Response back-pressure with a second requester waiting.
        bus.rsp_ready = 1'b0;
        stub_lat = 3;
        put(1, 8'd255, 8'd1);
        put(3, 8'd20, 8'd8);
        #1;
        wait_any_ready();
        chk("bp_grant", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid[1] = 1'b0;
        #1;
        wait_rsp("bp_rsp_seen");
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_hold%0d", k),
                {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req_ready},
                {1'b1, 2'd1, 8'd1, 1'b0, 4'd0});
            tick();
            #1;
        end
        bus.rsp_ready = 1'b1;
        tick();
        #1;
        chk("bp_next_ready", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid[3] = 1'b0;
        #1;
        chk("bp_next_busy", busy, 1);
        wait_rsp("bp_next_rsp_seen");
        chk("bp_next_rsp", {bus.rsp_id, bus.rsp_data, bus.rsp_err}, {2'd3, 8'd4, 1'b0});
        tick();
        #1;
        ptr = 3;

        // Hung unit: watchdog abort after TO cycles in WAIT.
        stub_lat = 0;
        put(0, 8'd5, 8'd10);
        #1;
        wait_any_ready();
        chk("to_grant", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        #1;
        chk("to_issue", gcd_start, 1);
        tick();
        #1;
        n = 0;
        while (!gcd_rst && n < 100) begin
            n++;
            tick();
            #1;
        end
        chk("to_wait_cycles", n, TO);
        tick();
        #1;
        chk("to_resp",
            {gcd_rst, bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_id},
            {1'b0, 1'b1, 1'b1, 8'd0, 2'd0});
        tick();
        #1;

        // Asynchronous reset in the middle of WAIT.
        put(2, 8'd9, 8'd3);
        #1;
        wait_any_ready();
        chk("rst_grant", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        repeat (5) tick();
        r0 = n_grst;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_outputs",
            {busy, gcd_start, gcd_rst, gcd_a, gcd_b, bus.rsp_valid,
             bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req_ready}, 0);
        tick();
        rst = 1'b0;
        #1;
        seen = 1'b0;
        repeat (5) begin
            if (bus.rsp_valid || busy) seen = 1'b1;
            tick();
            #1;
        end
        chk("rst_no_rsp", seen, 0);
        chk("rst_no_abort", n_grst - r0, 0);
        stub_lat = 2;
        put(0, 8'd21, 8'd14);
        put(3, 8'd6, 8'd4);
        #1;
        wait_any_ready();
        chk("rst_prio0", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        #1;
        wait_rsp("rst_rsp_seen");
        chk("rst_rsp", {bus.rsp_id, bus.rsp_data, bus.rsp_err}, {2'd0, 8'd7, 1'b0});
        tick();
        #1;
        ptr = 0;

        // Randomized traffic against the transaction-level model.
        for (int c = 0; c < 6000; c++) begin
            gen = (c < 3000);
            if (!gen && q.size() == 0 && pend == '0 && !busy) break;
            for (int i = 0; i < N; i++) begin
                if (gen && !pend[i] && $urandom_range(0, 3) == 0) begin
                    pa[i]   = rnd_op();
                    pb[i]   = rnd_op();
                    pend[i] = 1'b1;
                    put(i, pa[i], pb[i]);
                end
            end
            bus.rsp_ready = gen ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rand_rsp_queued", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rand_rsp", {bus.rsp_id, bus.rsp_data, bus.rsp_err}, {e.id, e.d, e.e});
                end
            end
            win = -1;
            if (bus.req_ready != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (win < 0 && pend[(ptr + k) % N]) win = (ptr + k) % N;
                end
                chk("rand_grant", bus.req_ready, (win < 0) ? 64'd0 : (64'(1) << win));
                if (win >= 0) begin
                    lat      = $urandom_range(1, 20);
                    stub_lat = lat;
                    bypass   = (pa[win] == '0) || (pb[win] == '0);
                    e.id     = 2'(win);
                    e.e      = !bypass && (lat > TO);
                    e.d      = e.e ? '0 : gcd_ref(pa[win], pb[win]);
                    q.push_back(e);
                    ptr = win;
                end
            end
            tick();
            if (win >= 0) begin
                pend[win]          = 1'b0;
                bus.req_valid[win] = 1'b0;
            end
        end
        chk("rand_drain", {32'(q.size()), 4'(pend), busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/gcd_rr_scheduler.md
Name: gcd_rr_scheduler

Overview:
Shares one subtraction-based GCD unit (controller plus datapath) between N_REQ requesters using round-robin arbitration. It accepts one request, drives the operands and a start pulse into the unit, waits for completion, and returns the result tagged with the requester ID. Zero operands bypass the unit, and a watchdog aborts a hung computation. Sits between client blocks and the single GCD instance.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 8, operand/result width
TIMEOUT, 1024, max cycles in WAIT before abort (must exceed worst-case GCD latency)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  N_REQ  per-requester request; operands held stable until accepted
req_a  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  operand B, same packing
req_ready  out  N_REQ  one-hot accept; request i accepted on edge where req_valid[i] & req_ready[i]
rsp_valid  out  1  response available
rsp_id  out  clog2(N_REQ)  requester index of the response
rsp_data  out  WIDTH  GCD result
rsp_err  out  1  1 = watchdog abort, rsp_data = 0
rsp_ready  in  1  response consumed on edge where rsp_valid & rsp_ready
busy  out  1  high in every state except IDLE
gcd_start  out  1  start pulse to the GCD unit
gcd_a  out  WIDTH  operand A to the unit (registered)
gcd_b  out  WIDTH  operand B to the unit (registered)
gcd_rst  out  1  synchronous reset pulse to the GCD unit (abort)
gcd_done  in  1  unit output-load strobe; result register updates at this edge
gcd_result  in  WIDTH  unit output register

Behaviour:
- Reset (async): state IDLE; all outputs 0; operand/result registers 0; watchdog 0; RR pointer last = N_REQ-1, so requester 0 has top priority first.
- States: IDLE, ISSUE, WAIT, CAPTURE, ABORT, RESP.
- IDLE: req_ready is combinational one-hot, selecting the first asserted req_valid scanning last+1, last+2, ... modulo N_REQ. It is all-zero if no request is valid. On accept:
  - latch operands into gcd_a/gcd_b and the winner ID into rsp_id;
  - set last = winner;
  - if either operand is 0, set rsp_data = a|b (GCD(0,x)=x, GCD(0,0)=0) and go to RESP (bypass, unit untouched);
  - otherwise go to ISSUE.
- ISSUE: gcd_start=1 for exactly one cycle; clear watchdog; go to WAIT.
- WAIT: gcd_start=0.
  - gcd_done=1 -> CAPTURE.
  - Else watchdog increments; when it reaches TIMEOUT-1 -> ABORT.
  - If gcd_done arrives on the same cycle the limit is reached, done wins.
- CAPTURE: rsp_data <= gcd_result (the unit's output is valid the cycle after its strobe); rsp_err <= 0; go to RESP.
- ABORT: gcd_rst=1 for one cycle; rsp_data <= 0; rsp_err <= 1; go to RESP.
- RESP: rsp_valid=1, with rsp_id, rsp_data and rsp_err held stable. Go to IDLE on rsp_ready; otherwise stay with no timeout.
- req_ready is 0 in every state except IDLE. Requests arriving while busy wait, and the pointer is unaffected.
- gcd_a/gcd_b are held constant from accept until the next accept, because the unit reloads operands continuously while idle.
- Latency with rsp_ready tied high:
  - bypass: accept -> rsp_valid on the next cycle;
  - normal: accept -> ISSUE -> WAIT (unit latency) -> CAPTURE -> RESP.
- rsp_ready while rsp_valid=0 is ignored.
- Reset mid-operation drops the transaction with no response. gcd_rst is not asserted; the unit is reset by its own rst.
- Watchdog width clog2(TIMEOUT+1); no wrap, since it is cleared in ISSUE.

Test Plan:
- Req0 a=12, b=18, model GCD unit, rsp_ready=1 -> req_ready[0] one cycle, one gcd_start pulse, rsp_valid with rsp_id=0, rsp_data=6, rsp_err=0; busy low after.
- Req2 a=0, b=35, then a=0, b=0 -> no gcd_start; rsp_data=35 then 0, one cycle after accept each.
- All four requesters valid continuously with a=b=7 -> grant order 0,1,2,3,0; each rsp_data=7 with matching rsp_id.
- Req1 a=255, b=1 with rsp_ready low for 10 cycles -> rsp_valid/data=1 held stable all 10 cycles; req_ready stays 0 for pending req3; req3 accepted in the cycle after the handshake.
- TIMEOUT=16, stub unit never asserts gcd_done -> 16 cycles in WAIT, gcd_rst one cycle, then rsp_valid with rsp_err=1, rsp_data=0.
- Assert rst asynchronously mid-WAIT -> all outputs 0 immediately, state IDLE, no response; next request served from requester 0.
